// File: rtl/booth_r4_mult_seq_if.sv
// rtl/booth_r4_mult_seq_if.sv - start/done handshake and operand/result bundle for the radix-4 multiplier
interface booth_r4_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, mcand, mplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, mcand, mplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_r4_mult_seq.sv
// rtl/booth_r4_mult_seq.sv - sequential radix-4 modified Booth multiplier, signed or unsigned per operation
module booth_r4_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  booth_r4_mult_seq_if.slave  bus
);
  // Operands carry two guard bits so unsigned values stay positive and +/-2Y never overflows.
  localparam int EW = WIDTH + 2;
  localparam int N  = EW / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [EW-1:0]        acc;
  logic [EW-1:0]        ycand;
  logic [EW:0]          mq;
  logic [2*WIDTH-1:0]   prod_q;

  logic                 accept;
  logic [EW-1:0]        ext_a;
  logic [EW-1:0]        ext_b;
  logic [EW-1:0]        pp;
  logic [EW-1:0]        sum;
  logic [EW-1:0]        acc_sh;
  logic [EW:0]          mq_sh;
  logic [2*WIDTH-1:0]   prod_full;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ext_a = bus.signed_mode ? {{2{bus.mcand[WIDTH-1]}}, bus.mcand}
                            : {2'b00, bus.mcand};
    ext_b = bus.signed_mode ? {{2{bus.mplier[WIDTH-1]}}, bus.mplier}
                            : {2'b00, bus.mplier};
  end

  // Booth digit from {b(i+1), b(i), b(i-1)}; mq[0] holds the implicit/previous bit.
  always_comb begin
    pp = '0;
    case (mq[2:0])
      3'b001, 3'b010: pp = ycand;
      3'b011:         pp = {ycand[EW-2:0], 1'b0};
      3'b100:         pp = -{ycand[EW-2:0], 1'b0};
      3'b101, 3'b110: pp = -ycand;
      default:        pp = '0;
    endcase
  end

  always_comb begin
    sum       = acc + pp;
    acc_sh    = {{2{sum[EW-1]}}, sum[EW-1:2]};
    mq_sh     = {sum[1:0], mq[EW:2]};
    prod_full = {acc_sh[2*WIDTH-EW-1:0], mq_sh[EW:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      ycand  <= '0;
      mq     <= '0;
      prod_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc   <= '0;
        ycand <= ext_a;
        mq    <= {ext_b, 1'b0};
        cnt   <= CNT_INIT;
      end else if (state == CALC) begin
        acc <= acc_sh;
        mq  <= mq_sh;
        if (cnt == '0) prod_q <= prod_full;
        else           cnt    <= cnt - 1'b1;
      end
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = (state == DONE);
  assign bus.product = prod_q;
endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// tb/tb_booth_r4_mult_seq.sv - directed and swept checks of booth_r4_mult_seq at WIDTH 8 and 16
module tb_booth_r4_mult_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_r4_mult_seq_if #(.WIDTH(8))  b8 ();
  booth_r4_mult_seq_if #(.WIDTH(16)) b16 ();

  booth_r4_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
  booth_r4_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit wide, input bit st, input bit sm, input logic [15:0] a, input logic [15:0] b);
    if (wide) begin
      b16.start = st; b16.signed_mode = sm; b16.mcand = a; b16.mplier = b;
    end else begin
      b8.start = st; b8.signed_mode = sm; b8.mcand = a[7:0]; b8.mplier = b[7:0];
    end
  endtask

  // Called #1 after the accepting edge; counts edges until done is seen.
  task automatic wait_done(input bit wide, output int lat, output int busyc, output logic [31:0] prod);
    logic d, bz;
    lat = 0;
    busyc = 0;
    while (lat < 40) begin
      d  = wide ? b16.done : b8.done;
      bz = wide ? b16.busy : b8.busy;
      if (d) break;
      busyc += int'(bz);
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) lat = -1;
    prod = wide ? b16.product : {16'h0, b8.product};
  endtask

  task automatic run_op(input bit wide, input bit sm, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] prod, output int lat, output int busyc, output logic done2);
    @(negedge clk);
    drive(wide, 1'b1, sm, a, b);
    @(posedge clk); #1;
    if (wide) b16.start = 1'b0; else b8.start = 1'b0;
    wait_done(wide, lat, busyc, prod);
    @(posedge clk); #1;
    done2 = wide ? b16.done : b8.done;
  endtask

  function automatic logic [31:0] ref_mul(input bit sm, input logic [15:0] a, input logic [15:0] b);
    logic signed [33:0] ea, eb;
    logic [31:0] r;
    ea = sm ? {{18{a[15]}}, a} : {18'h0, a};
    eb = sm ? {{18{b[15]}}, b} : {18'h0, b};
    r  = 32'(ea * eb);
    return r;
  endfunction

  initial begin
    vec_t vecs[12];
    logic [31:0] prod;
    int lat, busyc, lat2;
    logic done2, saw;
    bit sm;
    logic [15:0] a, b;

    vecs[0]  = '{1'b0, 8'd120, 8'd3,   16'h0168};
    vecs[1]  = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[2]  = '{1'b1, 8'hFF,  8'h7F,  16'hFF81};
    vecs[3]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[4]  = '{1'b0, 8'h00,  8'h00,  16'h0000};
    vecs[5]  = '{1'b1, 8'h7F,  8'h7F,  16'h3F01};
    vecs[6]  = '{1'b1, 8'h80,  8'h7F,  16'hC080};
    vecs[7]  = '{1'b0, 8'd128, 8'd2,   16'h0100};
    vecs[8]  = '{1'b1, 8'h80,  8'h01,  16'hFF80};
    vecs[9]  = '{1'b0, 8'h80,  8'h01,  16'h0080};
    vecs[10] = '{1'b1, 8'd5,   8'hFD,  16'hFFF1};
    vecs[11] = '{1'b0, 8'd200, 8'd100, 16'h4E20};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    #12;
    check("reset_busy", b8.busy, 0);
    check("reset_done", b8.done, 0);
    check("reset_product", b8.product, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, vecs[i].sm, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, prod, lat, busyc, done2);
      check($sformatf("vec%0d_product", i), prod, {16'h0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_busy_cycles", i), busyc, 5);
      check($sformatf("vec%0d_done_single", i), done2, 0);
    end

    // Second start mid-CALC with different operands must be ignored.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'd10, 16'd10);
    @(posedge clk); #1;
    b8.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'd3, 16'd3);
    @(posedge clk); #1;
    b8.start = 1'b0;
    wait_done(1'b0, lat, busyc, prod);
    check("midcalc_product", prod, 32'h0064);
    check("midcalc_latency", lat + 2, 5);
    @(posedge clk); #1;
    check("midcalc_no_restart_busy", b8.busy, 0);
    check("midcalc_no_restart_done", b8.done, 0);

    // Asynchronous reset in CALC cycle 3 clears outputs immediately and drops the op.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'd7, 16'd9);
    @(posedge clk); #1;
    b8.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", b8.busy, 0);
    check("async_rst_done", b8.done, 0);
    check("async_rst_product", b8.product, 0);
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      saw = saw | b8.done | b8.busy;
    end
    check("post_rst_no_done", saw, 0);
    check("post_rst_product", b8.product, 0);

    // start held high: back-to-back acceptance from DONE.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'd7, 16'd9);
    @(posedge clk); #1;
    wait_done(1'b0, lat, busyc, prod);
    check("held_first_product", prod, 32'h003F);
    check("held_first_latency", lat, 5);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h00FD, 16'd5);
    @(posedge clk); #1;
    wait_done(1'b0, lat2, busyc, prod);
    check("held_done_spacing", lat2 + 1, 6);
    check("held_second_product", prod, 32'hFFF1);
    @(negedge clk);
    b8.start = 1'b0;
    @(posedge clk); #1;
    check("held_stop_idle", b8.busy, 0);

    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        sm = 1'b1; a = 16'h8000; b = 16'h8000;
      end else if (i == 1) begin
        sm = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
      end else begin
        sm = 1'($urandom_range(0, 1));
        a  = 16'($urandom);
        b  = 16'($urandom);
      end
      run_op(1'b1, sm, a, b, prod, lat, busyc, done2);
      check($sformatf("w16_op%0d_product", i), prod, ref_mul(sm, a, b));
      check($sformatf("w16_op%0d_latency", i), lat, 9);
      check($sformatf("w16_op%0d_done_single", i), done2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
